// File: rtl/mio_pkg.sv
// Shared definitions for the memory/IO bus controller: region codes,
// region base nibbles and FSM state encoding.
package mio_pkg;

  typedef enum logic [1:0] {
    REG_RAM     = 2'd0,
    REG_GPIO    = 2'd1,
    REG_COUNTER = 2'd2,
    REG_NONE    = 2'd3
  } region_e;

  localparam logic [3:0] BASE_RAM     = 4'h0;
  localparam logic [3:0] BASE_GPIO    = 4'hE;
  localparam logic [3:0] BASE_COUNTER = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic region_e decode_region(input logic [3:0] nib);
    region_e r;
    case (nib)
      BASE_RAM:     r = REG_RAM;
      BASE_GPIO:    r = REG_GPIO;
      BASE_COUNTER: r = REG_COUNTER;
      default:      r = REG_NONE;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mio_bus_if.sv
// CPU-side load/store handshake between the CPU (master) and mio_bus (slave).
interface mio_bus_if;

  logic        CPU_MIO;
  logic        MemRW;
  logic [31:0] Addr_in;
  logic [31:0] Data_in;
  logic [31:0] Data_to_cpu;
  logic        MIO_ready;

  modport master (
    output CPU_MIO, MemRW, Addr_in, Data_in,
    input  Data_to_cpu, MIO_ready
  );

  modport slave (
    input  CPU_MIO, MemRW, Addr_in, Data_in,
    output Data_to_cpu, MIO_ready
  );

endinterface

// File: rtl/mio_counter.sv
// Free-running 32-bit up-counter with synchronous load; load wins over increment.
module mio_counter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [31:0] load_val,
  output logic [31:0] count
);

  logic [31:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q + 32'd1;
    if (load) cnt_d = load_val;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= 32'd0;
    else        cnt_q <= cnt_d;
  end

  assign count = cnt_q;

endmodule

// File: rtl/mio_bus.sv
// Memory/IO bus controller: decodes CPU addresses onto RAM, GPIO and counter,
// stalling the CPU for the duration of a RAM read.
//
// state | meaning
// IDLE  | accept request; writes and non-RAM reads complete this cycle
// WAIT  | RAM read in flight, counting down RAM_WAIT cycles
// DONE  | present latched RAM read data for one cycle
module mio_bus
  import mio_pkg::*;
#(
  parameter int RAM_WAIT = 1,
  parameter int RAM_AW   = 10
) (
  input  logic              clk,
  input  logic              rst,
  mio_bus_if.slave          cpu,
  output logic [RAM_AW-1:0] ram_addr,
  output logic              ram_we,
  output logic [31:0]       ram_din,
  input  logic [31:0]       ram_dout,
  input  logic [15:0]       switches,
  output logic [31:0]       gpio_out,
  output logic [31:0]       counter_out
);

  localparam logic [3:0] WAIT_INIT = 4'(RAM_WAIT - 1);

  state_e      state_d, state_q;
  logic [3:0]  wait_d, wait_q;
  logic [31:0] rd_d, rd_q;
  logic [31:0] gpio_d, gpio_q;
  logic        ready;
  logic [31:0] dout;
  logic        cnt_load;
  region_e     region;
  logic        unused_addr_bits;

  assign region           = decode_region(cpu.Addr_in[31:28]);
  assign ram_addr         = cpu.Addr_in[RAM_AW+1:2];
  assign ram_din          = cpu.Data_in;
  assign unused_addr_bits = ^{cpu.Addr_in[27:RAM_AW+2], cpu.Addr_in[1:0]};

  always_comb begin
    state_d  = state_q;
    wait_d   = wait_q;
    rd_d     = rd_q;
    gpio_d   = gpio_q;
    ready    = 1'b1;
    dout     = 32'd0;
    ram_we   = 1'b0;
    cnt_load = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cpu.CPU_MIO) begin
          case (region)
            REG_RAM: begin
              if (cpu.MemRW) begin
                ram_we = 1'b1;
              end else begin
                ready   = 1'b0;
                wait_d  = WAIT_INIT;
                state_d = ST_WAIT;
              end
            end
            REG_GPIO: begin
              if (cpu.MemRW) gpio_d = cpu.Data_in;
              else           dout   = {16'h0, switches};
            end
            REG_COUNTER: begin
              if (cpu.MemRW) cnt_load = 1'b1;
              else           dout     = counter_out;
            end
            default: ;
          endcase
        end
      end
      ST_WAIT: begin
        ready = 1'b0;
        // A dropped request abandons the read; the read register keeps its old value.
        if (!cpu.CPU_MIO) begin
          state_d = ST_IDLE;
        end else if (wait_q == 4'd0) begin
          rd_d    = ram_dout;
          state_d = ST_DONE;
        end else begin
          wait_d = wait_q - 4'd1;
        end
      end
      ST_DONE: begin
        if (cpu.CPU_MIO) dout = rd_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      wait_q  <= 4'd0;
      rd_q    <= 32'd0;
      gpio_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      rd_q    <= rd_d;
      gpio_q  <= gpio_d;
    end
  end

  mio_counter u_counter (
    .clk      (clk),
    .rst_n    (rst),
    .load     (cnt_load),
    .load_val (cpu.Data_in),
    .count    (counter_out)
  );

  assign gpio_out        = gpio_q;
  assign cpu.MIO_ready   = ready;
  assign cpu.Data_to_cpu = dout;

endmodule

// File: doc/mio_bus.md
# mio_bus

Memory/IO bus controller sitting directly downstream of the single-cycle CPU. It decodes the CPU data address and routes load/store traffic to the data RAM, a GPIO register and a free-running counter. It returns read data and generates `MIO_ready`, stalling the CPU while a RAM read is in flight.

## Interface
Parameters:
- `RAM_WAIT`, 1: RAM read latency in cycles (1–15).
- `RAM_AW`, 10: RAM word-address width.

Ports:
- `clk`  in  1  system clock; all logic is rising-edge.
- `rst`  in  1  reset; asynchronous, active-low.
- `CPU_MIO`  in  1  CPU bus request; high for the whole of a load/store instruction.
- `MemRW`  in  1  1 = write, 0 = read.
- `Addr_in`  in  32  CPU byte address (the CPU ALU result).
- `Data_in`  in  32  CPU store data.
- `Data_to_cpu`  out  32  load data returned to the CPU.
- `MIO_ready`  out  1  transaction complete / CPU may advance.
- `ram_addr`  out  RAM_AW  RAM word address = `Addr_in[RAM_AW+1:2]`.
- `ram_we`  out  1  RAM write strobe.
- `ram_din`  out  32  RAM write data (= `Data_in`).
- `ram_dout`  in  32  RAM read data, valid `RAM_WAIT` cycles after the address.
- `switches`  in  16  board switches.
- `gpio_out`  out  32  LED/GPIO register.
- `counter_out`  out  32  current counter value.

## Operation
- Address decode on `Addr_in[31:28]`:
  - 0x0 is RAM.
  - 0xE is GPIO.
  - 0xF is COUNTER.
  - Anything else is NONE.
- FSM states: IDLE, WAIT, DONE. `rst` low forces IDLE.
- IDLE, with `CPU_MIO`=1:
  - RAM write: `ram_we`=1 this cycle, `MIO_ready`=1, stay IDLE.
  - RAM read: `MIO_ready`=0, load wait counter with `RAM_WAIT`-1, go WAIT.
  - GPIO write: `gpio_out` <= `Data_in` at the clock edge, `MIO_ready`=1.
  - GPIO read: `Data_to_cpu` = {16'h0, `switches`}, `MIO_ready`=1.
  - COUNTER write: counter <= `Data_in` (load beats increment), `MIO_ready`=1.
  - COUNTER read: `Data_to_cpu` = counter, `MIO_ready`=1.
  - NONE: write is ignored, read returns 0, `MIO_ready`=1.
- IDLE, with `CPU_MIO`=0: `MIO_ready`=1, `ram_we`=0, `Data_to_cpu`=0.
- WAIT:
  - `MIO_ready`=0.
  - Decrement the wait counter each cycle.
  - At 0, latch `ram_dout` into the read register and go DONE.
- DONE: `MIO_ready`=1, `Data_to_cpu` = read register, then go IDLE.
- Abort: `CPU_MIO` falling in WAIT or DONE returns the FSM to IDLE with no data.
- Counter:
  - Increments by 1 every cycle.
  - Wraps from 0xFFFF_FFFF to 0.
  - `counter_out` = counter.
- `ram_we` is only ever high in IDLE with `CPU_MIO`=1, `MemRW`=1 and decode = RAM.

## Timing
- Reset values: state IDLE, `gpio_out`=0, counter=0, read register=0, `MIO_ready`=1, `ram_we`=0, `Data_to_cpu`=0.
- Write and non-RAM read outputs are combinational from the inputs in the same cycle.
- RAM read occupancy:
  - IDLE takes 1 cycle, WAIT takes `RAM_WAIT` cycles, DONE takes 1 cycle.
  - `MIO_ready` is low for exactly `RAM_WAIT`+1 cycles.
- The CPU holds `Addr_in`, `MemRW` and `CPU_MIO` stable while `MIO_ready`=0.
- A back-to-back request after DONE is accepted in the following IDLE cycle.
- `rst` asserted mid-transaction:
  - Immediate IDLE, `MIO_ready`=1.
  - `gpio_out` and counter clear.
  - Any pending read is lost.

## Structure
- Shared package `mio_pkg`:
  - Region codes RAM/GPIO/COUNTER/NONE.
  - Region base nibbles 0x0, 0xE, 0xF.
  - FSM state encoding.
- Sub-module `mio_counter` (counter with load, async active-low reset); everything else stays in `mio_bus`.

## Test plan
- Reset: hold `rst`=0 for 3 cycles, then release. Required: `gpio_out`=0, `counter_out`=0 on the first cycle after release and 1 on the next, `MIO_ready`=1.
- GPIO: write 0xDEAD_BEEF to 0xE000_0000, then read it back with `switches`=0x00A5. Required: `gpio_out`=0xDEAD_BEEF after the edge; read returns 0x0000_00A5 with `MIO_ready`=1 in the same cycle.
- RAM write/read, `RAM_WAIT`=2: write 0x1234_5678 to 0x0000_0010, then read 0x0000_0010.
  - Write: `ram_we` pulses for 1 cycle with `ram_addr`=4.
  - Read: `MIO_ready` is low for 3 cycles, then `Data_to_cpu`=0x1234_5678 for 1 cycle.
- Counter: write 0xFFFF_FFFE to 0xF000_0000, then idle. Required: `counter_out` reads 0xFFFF_FFFE, 0xFFFF_FFFF, 0, 1 on successive cycles.
- Abort/reset mid-read: drop `CPU_MIO` in WAIT, and separately assert `rst` in WAIT. Required in both cases: IDLE on the next cycle, `MIO_ready`=1, read register unchanged or 0.
- Unmapped: write then read 0x8000_0000. Required: no `ram_we`, `gpio_out` unchanged, read returns 0, `MIO_ready`=1.
